// File: rtl/life_bank_scheduler_pkg.sv
// Shared definitions for the Game-of-Life generation scheduler: FSM encoding,
// frame-store geometry and bank-select constants.
// No logic; latency/backpressure are properties of the modules that import this.
package life_bank_scheduler_pkg;

  // Frame store geometry: rows per BRAM bank and the row address width.
  localparam int Y_SIZE  = 720;
  localparam int Y_WIDTH = $clog2(Y_SIZE);

  // Bank select values as seen on rd_bank / wr_bank / cur_bank.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Scheduler states. The encoding is visible on sched_state for debug.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTE   = 2'd1,
    ST_WAIT_SWAP = 2'd2,
    ST_LOAD      = 2'd3
  } sched_state_t;

  // The bank that is not the given one (the bank receiving the next generation).
  function automatic logic other_bank(input logic bank);
    return (bank == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/life_bank_scheduler_sched_arbiter.sv
// Read-port arbiter for the displayed bank: fixed display priority, row mux, rvalid delay lines.
// Latency: grant and rd_addr are combinational; rvalid follows its grant by exactly RD_LAT cycles.
// Backpressure: none; the display is always granted, compute only gets the port when the display is idle.
module sched_arbiter
  import life_bank_scheduler_pkg::*;
#(
  parameter int Y_WIDTH = life_bank_scheduler_pkg::Y_WIDTH,
  parameter int RD_LAT  = 1
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic               disp_req,
  input  logic [Y_WIDTH-1:0] disp_row,
  input  logic               comp_req,
  input  logic [Y_WIDTH-1:0] comp_row,
  input  logic               comp_en,
  output logic               disp_gnt,
  output logic               comp_gnt,
  output logic [Y_WIDTH-1:0] rd_addr,
  output logic               disp_rvalid,
  output logic               comp_rvalid
);

  // Address of the most recent granted read; the port holds it while idle so
  // the BRAM address bus does not toggle needlessly.
  logic [Y_WIDTH-1:0] rd_addr_q;

  // One stage per cycle of BRAM latency, per requester.
  logic [RD_LAT-1:0] disp_pipe;
  logic [RD_LAT-1:0] comp_pipe;

  // Priority grant and row mux: display always wins, compute only while a generation runs.
  always_comb begin
    disp_gnt = disp_req;
    comp_gnt = comp_req & ~disp_req & comp_en;
    rd_addr  = rd_addr_q;
    if (disp_gnt) begin
      rd_addr = disp_row;
    end else if (comp_gnt) begin
      rd_addr = comp_row;
    end
  end

  // Remember the last granted row address.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      rd_addr_q <= '0;
    end else if (disp_gnt || comp_gnt) begin
      rd_addr_q <= rd_addr;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat_one
      // Single-stage delay of each grant to line up with BRAM dout.
      always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
          disp_pipe <= '0;
          comp_pipe <= '0;
        end else begin
          disp_pipe <= disp_gnt;
          comp_pipe <= comp_gnt;
        end
      end
    end else begin : g_lat_multi
      // Multi-stage shift of each grant to line up with BRAM dout.
      always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
          disp_pipe <= '0;
          comp_pipe <= '0;
        end else begin
          disp_pipe <= {disp_pipe[RD_LAT-2:0], disp_gnt};
          comp_pipe <= {comp_pipe[RD_LAT-2:0], comp_gnt};
        end
      end
    end
  endgenerate

  assign disp_rvalid = disp_pipe[RD_LAT-1];
  assign comp_rvalid = comp_pipe[RD_LAT-1];

endmodule

// File: rtl/life_bank_scheduler.sv
// Generation scheduler for the ping-pong Game-of-Life frame store (banks A/B) plus read/write port steering.
// Latency: grants, rd_addr and wr_* are zero-cycle combinational; gen_start/gen_abort are registered pulses.
// Backpressure: pause holds the FSM in IDLE; the display read always wins the port. Option: SCHED_STEP_EN.
module life_bank_scheduler
  import life_bank_scheduler_pkg::*;
#(
  parameter int Y_SIZE  = life_bank_scheduler_pkg::Y_SIZE,
  parameter int Y_WIDTH = $clog2(Y_SIZE),
  parameter int RD_LAT  = 1
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic               pause,
  input  logic               step,
  input  logic               load_en,
  input  logic               load_wr,
  input  logic [Y_WIDTH-1:0] load_row,
  input  logic               frame_sof,
  input  logic               disp_req,
  input  logic [Y_WIDTH-1:0] disp_row,
  output logic               disp_gnt,
  output logic               disp_rvalid,
  input  logic               comp_req,
  input  logic [Y_WIDTH-1:0] comp_row,
  output logic               comp_gnt,
  output logic               comp_rvalid,
  input  logic               comp_wr,
  input  logic [Y_WIDTH-1:0] comp_wr_row,
  output logic               gen_start,
  output logic               gen_abort,
  input  logic               gen_done,
  output logic               rd_bank,
  output logic [Y_WIDTH-1:0] rd_addr,
  output logic               wr_bank,
  output logic [Y_WIDTH-1:0] wr_addr,
  output logic               wr_en,
  output logic               cur_bank,
  output logic [31:0]        gen_count,
  output logic [1:0]         sched_state
);

  sched_state_t state;
  logic         cur_bank_q;
  logic [31:0]  gen_count_q;
  logic         gen_start_q;
  logic         gen_abort_q;
  logic         start_ok;

  // Whether IDLE may launch a new generation this cycle.
`ifdef SCHED_STEP_EN
  // A step pulse launches exactly one generation while paused.
  assign start_ok = ~pause | step;
`else
  // Pause freezes progression completely; step has no effect.
  assign start_ok = ~pause;
  logic unused_step;
  assign unused_step = step;
`endif

  // Generation sequencing: start, abort on host load, swap banks at the next frame boundary.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state       <= ST_IDLE;
      cur_bank_q  <= BANK_A;
      gen_count_q <= '0;
      gen_start_q <= 1'b0;
      gen_abort_q <= 1'b0;
    end else begin
      gen_start_q <= 1'b0;
      gen_abort_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            state <= ST_LOAD;
          end else if (start_ok) begin
            gen_start_q <= 1'b1;
            state       <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // Host load takes precedence over a completing generation.
          if (load_en) begin
            gen_abort_q <= 1'b1;
            state       <= ST_LOAD;
          end else if (gen_done) begin
            state <= ST_WAIT_SWAP;
          end
        end
        ST_WAIT_SWAP: begin
          // The swap waits only for the frame boundary, never for pause, so the
          // displayed image cannot tear mid-frame.
          if (load_en) begin
            state <= ST_LOAD;
          end else if (frame_sof) begin
            cur_bank_q  <= other_bank(cur_bank_q);
            gen_count_q <= gen_count_q + 32'd1;
            state       <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          // A freshly loaded pattern is generation zero.
          if (!load_en) begin
            gen_count_q <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write steering: the engine fills the hidden bank, the host writes the shown bank.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = cur_bank_q;
    wr_addr = load_row;
    if (state == ST_COMPUTE) begin
      wr_bank = other_bank(cur_bank_q);
      wr_addr = comp_wr_row;
      wr_en   = comp_wr;
    end else if (state == ST_LOAD) begin
      wr_en = load_wr;
    end
  end

  sched_arbiter #(
    .Y_WIDTH (Y_WIDTH),
    .RD_LAT  (RD_LAT)
  ) u_sched_arbiter (
    .out_stream_aclk (out_stream_aclk),
    .periph_resetn   (periph_resetn),
    .disp_req        (disp_req),
    .disp_row        (disp_row),
    .comp_req        (comp_req),
    .comp_row        (comp_row),
    .comp_en         (state == ST_COMPUTE),
    .disp_gnt        (disp_gnt),
    .comp_gnt        (comp_gnt),
    .rd_addr         (rd_addr),
    .disp_rvalid     (disp_rvalid),
    .comp_rvalid     (comp_rvalid)
  );

  // The read port always serves the displayed bank.
  assign rd_bank     = cur_bank_q;
  assign cur_bank    = cur_bank_q;
  assign gen_count   = gen_count_q;
  assign gen_start   = gen_start_q;
  assign gen_abort   = gen_abort_q;
  assign sched_state = state;

endmodule
